// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0 exception/interrupt controller (STATUS, CAUSE, EPC).
// Define EXC_CTRL_TIMER_EN to add COUNT/COMPARE and the CAUSE.TI timer interrupt.
module exc_ctrl #(
  parameter int          NUM_INT    = 6,
  parameter logic [31:0] EBASE_BOOT = 32'hBFC00000,
  parameter logic [31:0] EBASE_NORM = 32'h80000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_valid,
  input  logic [31:0]        wb_pc,
  input  logic               wb_bd,
  input  logic [3:0]         wb_excvec,
  input  logic               eret,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_addr,
  input  logic [31:0]        mtc0_wdata,
  input  logic [4:0]         mfc0_addr,
  output logic [31:0]        mfc0_rdata,
  output logic               exc,
  output logic [31:0]        exc_addr,
  output logic [31:0]        epc_out,
  output logic               status_exl
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] CODE_INT = 5'h00;
  localparam logic [4:0] CODE_SYS = 5'h08;
  localparam logic [4:0] CODE_BRK = 5'h09;
  localparam logic [4:0] CODE_RI  = 5'h0A;
  localparam logic [4:0] CODE_OV  = 5'h0C;

  typedef enum logic {
    NORMAL,
    HANDLER
  } state_t;

  state_t             state;
  logic               ie;
  logic               bev;
  logic [7:0]         im;
  logic               bd;
  logic               iv;
  logic [1:0]         ip_sw;
  logic [NUM_INT-1:0] ip_hw;
  logic [4:0]         exc_code;
  logic [31:0]        epc;

`ifdef EXC_CTRL_TIMER_EN
  logic               ti;
  logic [31:0]        count;
  logic [31:0]        compare;
`else
  logic               ti;
  assign ti = 1'b0;
`endif

  logic               exl;
  logic [5:0]         hw_ext;
  logic [7:0]         ip;
  logic               sync_exc;
  logic               int_pend;
  logic [4:0]         code_next;
  logic [31:0]        vec_base;
  logic [31:0]        status_rd;
  logic [31:0]        cause_rd;

  assign exl    = (state == HANDLER);
  assign hw_ext = 6'(ip_hw);
  assign ip     = {hw_ext[5] | ti, hw_ext[4:0], ip_sw};

  assign sync_exc = wb_valid & (|wb_excvec);
  assign int_pend = (|(ip & im)) & ie & ~exl
                  & wb_valid & ~(|wb_excvec);
  assign exc      = ~rst & (sync_exc | int_pend);

  // wb_excvec = {break, overflow, syscall, reserved-instr}
  always_comb begin
    code_next = CODE_INT;
    priority case (1'b1)
      wb_excvec[2]: code_next = CODE_OV;
      wb_excvec[1]: code_next = CODE_SYS;
      wb_excvec[3]: code_next = CODE_BRK;
      wb_excvec[0]: code_next = CODE_RI;
      default:      code_next = CODE_INT;
    endcase
  end

  // Boot vectors sit 0x200 above the boot ROM base.
  assign vec_base = bev ? (EBASE_BOOT + 32'h200) : EBASE_NORM;
  assign exc_addr = vec_base
                  + ((~sync_exc & iv) ? 32'h200 : 32'h180);

  assign status_rd = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
  assign cause_rd  = {bd, ti, 6'b0, iv, 7'b0, ip,
                      1'b0, exc_code, 2'b0};

  always_comb begin
    mfc0_rdata = 32'h0;
    unique case (mfc0_addr)
      REG_STATUS:  mfc0_rdata = status_rd;
      REG_CAUSE:   mfc0_rdata = cause_rd;
      REG_EPC:     mfc0_rdata = epc;
`ifdef EXC_CTRL_TIMER_EN
      REG_COUNT:   mfc0_rdata = count;
      REG_COMPARE: mfc0_rdata = compare;
`endif
      default:     mfc0_rdata = 32'h0;
    endcase
  end

  assign epc_out    = epc;
  assign status_exl = exl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      ie       <= 1'b0;
      bev      <= 1'b1;
      im       <= 8'h0;
      bd       <= 1'b0;
      iv       <= 1'b0;
      ip_sw    <= 2'b0;
      ip_hw    <= '0;
      exc_code <= 5'h0;
      epc      <= 32'h0;
`ifdef EXC_CTRL_TIMER_EN
      ti       <= 1'b0;
      count    <= 32'h0;
      compare  <= 32'h0;
`endif
    end else begin
      ip_hw <= int_in;
`ifdef EXC_CTRL_TIMER_EN
      if (mtc0_we && mtc0_addr == REG_COUNT)
        count <= mtc0_wdata;
      else
        count <= count + 32'd1;
      if (mtc0_we && mtc0_addr == REG_COMPARE) begin
        compare <= mtc0_wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
`endif
      if (mtc0_we) begin
        unique case (mtc0_addr)
          REG_STATUS: begin
            ie    <= mtc0_wdata[0];
            state <= mtc0_wdata[1] ? HANDLER : NORMAL;
            im    <= mtc0_wdata[15:8];
            bev   <= mtc0_wdata[22];
          end
          REG_CAUSE: begin
            iv    <= mtc0_wdata[23];
            ip_sw <= mtc0_wdata[9:8];
          end
          REG_EPC: epc <= mtc0_wdata;
          default: ;
        endcase
      end
      if (eret && exl)
        state <= NORMAL;
      // Exception-owned fields override any same-cycle mtc0/eret.
      if (exc) begin
        state    <= HANDLER;
        exc_code <= code_next;
        if (!exl) begin
          epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          bd  <= wb_bd;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scenario tasks for exc_ctrl with a queue of expected values.
// Timer scenario follows EXC_CTRL_TIMER_EN like the design.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [3:0]  wb_excvec;
  logic        eret;
  logic [5:0]  int_in;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        exc;
  logic [31:0] exc_addr;
  logic [31:0] epc_out;
  logic        status_exl;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp;
  logic [31:0] v;

  exc_ctrl #(.NUM_INT(6)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_bd(wb_bd), .wb_excvec(wb_excvec),
    .eret(eret), .int_in(int_in),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr),
    .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr),
    .mfc0_rdata(mfc0_rdata), .exc(exc),
    .exc_addr(exc_addr), .epc_out(epc_out),
    .status_exl(status_exl)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wb_valid   = 1'b0;
    wb_pc      = 32'h0;
    wb_bd      = 1'b0;
    wb_excvec  = 4'h0;
    eret       = 1'b0;
    mtc0_we    = 1'b0;
    mtc0_addr  = 5'd0;
    mtc0_wdata = 32'h0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0_addr = a;
    #1;
    d = mfc0_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we    = 1'b1;
    mtc0_addr  = a;
    mtc0_wdata = d;
    tick();
    mtc0_we    = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    int_in = 6'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    int_in = 6'h0;
    rst = 1'b1;
    wb_valid = 1'b1; wb_excvec = 4'b0001;
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_wdata = 32'h1234;
    sb.push_back(32'h0);
    #2;
    exp = sb.pop_front(); checks++;
    if ({31'b0, exc} !== exp) begin
      errors++; $display("FAIL rst_exc: got %h want %h", exc, exp);
    end
    tick();
    tick();
    idle();
    rst = 1'b0;
    sb.push_back(32'h00400000);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    rd(5'd12, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL rst_status: got %h want %h", v, exp);
    end
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL rst_cause: got %h want %h", v, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp || status_exl !== 1'b0) begin
      errors++;
      $display("FAIL rst_epc_exl: got %h/%b want %h/0",
               epc_out, status_exl, exp);
    end
  endtask

  task automatic test_syscall;
    wb_valid = 1'b1; wb_pc = 32'h100; wb_excvec = 4'b0010;
    sb.push_back(32'hBFC00380);
    #2;
    exp = sb.pop_front(); checks++;
    if (exc !== 1'b1 || exc_addr !== exp) begin
      errors++;
      $display("FAIL sys_vec: got %b/%h want 1/%h", exc, exc_addr, exp);
    end
    sb.push_back(32'h100);
    sb.push_back(32'h08);
    tick();
    idle();
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp || status_exl !== 1'b1) begin
      errors++;
      $display("FAIL sys_epc: got %h/%b want %h/1", epc_out, status_exl, exp);
    end
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({27'b0, v[6:2]} !== exp || v[31] !== 1'b0) begin
      errors++;
      $display("FAIL sys_code: got %h bd %b want %h bd 0", v[6:2], v[31], exp);
    end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    sb.push_back(32'h100);
    exp = sb.pop_front(); checks++;
    if (status_exl !== 1'b0 || epc_out !== exp) begin
      errors++;
      $display("FAIL sys_eret: got %b/%h want 0/%h", status_exl, epc_out, exp);
    end
  endtask

  task automatic test_interrupt;
    wr(5'd12, 32'h00000401);
    wr(5'd13, 32'h00800000);
    int_in = 6'b000001;
    wb_valid = 1'b1; wb_pc = 32'h400;
    sb.push_back(32'h0);
    #2;
    exp = sb.pop_front(); checks++;
    if ({31'b0, exc} !== exp) begin
      errors++; $display("FAIL int_latency: got %h want %h", exc, exp);
    end
    tick();
    sb.push_back(32'h80000200);
    #2;
    exp = sb.pop_front(); checks++;
    if (exc !== 1'b1 || exc_addr !== exp) begin
      errors++;
      $display("FAIL int_vec: got %b/%h want 1/%h", exc, exc_addr, exp);
    end
    tick();
    wb_valid = 1'b0;
    sb.push_back(32'h00000400);
    sb.push_back(32'h400);
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({16'b0, v[15:8], 1'b0, v[6:2], 2'b0} !== exp) begin
      errors++; $display("FAIL int_cause: got %h want %h", v, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp || status_exl !== 1'b1) begin
      errors++;
      $display("FAIL int_epc: got %h/%b want %h/1", epc_out, status_exl, exp);
    end
    wb_valid = 1'b1;
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if ({31'b0, exc} !== exp) begin
      errors++; $display("FAIL int_masked_exl: got %h want %h", exc, exp);
    end
    wb_valid = 1'b0;
    int_in = 6'h0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_priority_bd;
    wb_valid = 1'b1; wb_pc = 32'h2004; wb_bd = 1'b1;
    wb_excvec = 4'b0110;
    sb.push_back(32'h80000180);
    #2;
    exp = sb.pop_front(); checks++;
    if (exc !== 1'b1 || exc_addr !== exp) begin
      errors++;
      $display("FAIL ov_vec: got %b/%h want 1/%h", exc, exc_addr, exp);
    end
    sb.push_back(32'h8000_000C);
    sb.push_back(32'h2000);
    tick();
    idle();
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({v[31], 26'b0, v[6:2]} !== exp) begin
      errors++; $display("FAIL ov_cause: got %h want %h", v, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp) begin
      errors++; $display("FAIL ov_epc: got %h want %h", epc_out, exp);
    end
  endtask

  task automatic test_nested;
    wb_valid = 1'b1; wb_pc = 32'h300; wb_excvec = 4'b0001;
    sb.push_back(32'h80000180);
    #2;
    exp = sb.pop_front(); checks++;
    if (exc !== 1'b1 || exc_addr !== exp) begin
      errors++;
      $display("FAIL nest_vec: got %b/%h want 1/%h", exc, exc_addr, exp);
    end
    sb.push_back(32'h8000_000A);
    sb.push_back(32'h2000);
    tick();
    idle();
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({v[31], 26'b0, v[6:2]} !== exp || status_exl !== 1'b1) begin
      errors++;
      $display("FAIL nest_cause: got %h exl %b want %h exl 1",
               v, status_exl, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp) begin
      errors++; $display("FAIL nest_epc: got %h want %h", epc_out, exp);
    end
    eret = 1'b1;
    sb.push_back(32'h2000);
    tick();
    eret = 1'b0;
    exp = sb.pop_front(); checks++;
    if (status_exl !== 1'b0 || epc_out !== exp) begin
      errors++;
      $display("FAIL nest_eret: got %b/%h want 0/%h", status_exl, epc_out, exp);
    end
  endtask

  task automatic test_back_to_back;
    wb_valid = 1'b1; wb_pc = 32'h500; wb_excvec = 4'b1000;
    sb.push_back(32'h09);
    tick();
    wb_pc = 32'h504; wb_excvec = 4'b0001; eret = 1'b1;
    sb.push_back(32'h0A);
    sb.push_back(32'h500);
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({27'b0, v[6:2]} !== exp) begin
      errors++; $display("FAIL brk_code: got %h want %h", v[6:2], exp);
    end
    tick();
    idle();
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({27'b0, v[6:2]} !== exp || status_exl !== 1'b1) begin
      errors++;
      $display("FAIL exc_eret_code: got %h exl %b want %h exl 1",
               v[6:2], status_exl, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp) begin
      errors++; $display("FAIL exc_eret_epc: got %h want %h", epc_out, exp);
    end
    eret = 1'b1;
    tick();
    sb.push_back(32'h0);
    tick();
    eret = 1'b0;
    exp = sb.pop_front(); checks++;
    if ({31'b0, status_exl} !== exp) begin
      errors++; $display("FAIL eret_idle: got %h want %h", status_exl, exp);
    end
  endtask

  task automatic test_mtc0;
    mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0000FF00;
    wb_valid = 1'b1; wb_pc = 32'h600; wb_excvec = 4'b0100;
    sb.push_back(32'h0000FF02);
    sb.push_back(32'h600);
    tick();
    idle();
    rd(5'd12, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL mtc0_exc_status: got %h want %h", v, exp);
    end
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp) begin
      errors++; $display("FAIL mtc0_exc_epc: got %h want %h", epc_out, exp);
    end
    wb_excvec = 4'b1111;
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if ({31'b0, exc} !== exp) begin
      errors++; $display("FAIL no_valid: got %h want %h", exc, exp);
    end
    wb_excvec = 4'b0000;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    wr(5'd14, 32'hDEADBEEF);
    wr(5'd13, 32'h00000300);
    sb.push_back(32'hDEADBEEF);
    sb.push_back(32'h300);
    exp = sb.pop_front(); checks++;
    if (epc_out !== exp) begin
      errors++; $display("FAIL mtc0_epc: got %h want %h", epc_out, exp);
    end
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({22'b0, v[9:8], 8'b0} !== exp || v[23] !== 1'b0) begin
      errors++; $display("FAIL mtc0_cause: got %h want %h", v, exp);
    end
  endtask

  task automatic test_timer;
`ifdef EXC_CTRL_TIMER_EN
    do_reset();
    wr(5'd11, 32'd5);
    v = 32'h0;
    for (int i = 0; i < 20 && v[30] !== 1'b1; i++) begin
      tick();
      rd(5'd13, v);
    end
    sb.push_back(32'h4000_8000);
    sb.push_back(32'd6);
    sb.push_back(32'h0);
    exp = sb.pop_front(); checks++;
    if ({1'b0, v[30], 14'b0, v[15], 15'b0} !== exp) begin
      errors++; $display("FAIL timer_ti: got %h want %h", v, exp);
    end
    rd(5'd9, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL timer_count: got %h want %h", v, exp);
    end
    wr(5'd11, 32'd1000);
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({v[30], v[15]} !== exp[1:0]) begin
      errors++; $display("FAIL timer_clear: got %h want ti=0 ip15=0", v);
    end
`else
    wr(5'd9, 32'h0000FFFF);
    wr(5'd11, 32'h00000003);
    tick();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    rd(5'd9, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL no_timer_count: got %h want %h", v, exp);
    end
    rd(5'd11, v);
    exp = sb.pop_front(); checks++;
    if (v !== exp) begin
      errors++; $display("FAIL no_timer_compare: got %h want %h", v, exp);
    end
    rd(5'd13, v);
    exp = sb.pop_front(); checks++;
    if ({31'b0, v[30]} !== exp) begin
      errors++; $display("FAIL no_timer_ti: got %h want %h", v[30], exp);
    end
`endif
  endtask

  initial begin
    mfc0_addr = 5'd0;
    idle();
    int_in = 6'h0;
    rst = 1'b1;
    test_reset();
    test_syscall();
    test_interrupt();
    test_priority_bd();
    test_nested();
    test_back_to_back();
    test_mtc0();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
